// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through reads,
// occupancy count, programmable almost flags, sticky error flags and synchronous flush.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       wr,
    input  logic                       rd,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CW-1:0]     cnt;
    logic              ovf;
    logic              unf;
    logic              rd_ok;
    logic              wr_ok;

    // A write into a full FIFO is accepted only when a read frees the head slot
    // in the same cycle; a read of an empty FIFO never bypasses the write.
    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd_ok);

    assign empty        = (cnt == '0);
    assign full         = (cnt == DEPTH_C);
    assign almost_empty = (cnt <= AE_C);
    assign almost_full  = (cnt >= AF_C);
    assign count        = cnt;
    assign overflow     = ovf;
    assign underflow    = unf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (wr && !wr_ok) ovf <= 1'b1;
            if (rd && !rd_ok) unf <= 1'b1;
        end
    end

    // Storage has no reset so it maps onto RAM; flush and reset only move pointers.
    always_ff @(posedge clk) begin
        if (wr_ok && !clr && !rst) mem[wptr] <= din;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = empty ? '0 : mem[rptr];
        end else begin : g_std
            logic [DATA_W-1:0] dout_r;
            // Nonblocking read of mem returns the old word on a same-address write.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)        dout_r <= '0;
                else if (clr)   dout_r <= '0;
                else if (rd_ok) dout_r <= mem[rptr];
            end
            assign dout = dout_r;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a standard-read instance and a FWFT instance
// share the stimulus; each scenario task checks its own expected values inline.
module tb_sync_fifo_param;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       wr  = 1'b0;
    logic       rd  = 1'b0;
    logic [7:0] din = 8'h00;

    logic [7:0] dout0, dout1;
    logic       empty0, full0, aempty0, afull0, ovf0, unf0;
    logic       empty1, full1, aempty1, afull1, ovf1, unf1;
    logic [4:0] count0, count1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr), .rd(rd), .din(din),
        .dout(dout0), .empty(empty0), .full(full0), .almost_empty(aempty0),
        .almost_full(afull0), .count(count0), .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .wr(wr), .rd(rd), .din(din),
        .dout(dout1), .empty(empty1), .full(full1), .almost_empty(aempty1),
        .almost_full(afull1), .count(count1), .overflow(ovf1), .underflow(unf1)
    );

    // Drive one cycle of requests, then release them 1 ns after the edge.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        wr = w; rd = r; din = d;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0; clr = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        pulse_reset();
        cyc(1'b1, 1'b0, 8'h3C);
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b0, 8'h44);
        cyc(1'b1, 1'b0, 8'h45);
        n_cmp++; if (dout0 !== 8'h3C) begin n_err++; $display("FAIL pre_reset_dout got %h want 3c", dout0); end
        n_cmp++; if (count0 !== 5'd2) begin n_err++; $display("FAIL pre_reset_count got %0d want 2", count0); end
        @(posedge clk); #3; rst = 1'b1; #1;
        n_cmp++; if (empty0 !== 1'b1 || aempty0 !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b%b want 11", empty0, aempty0); end
        n_cmp++; if (full0 !== 1'b0 || afull0 !== 1'b0) begin n_err++; $display("FAIL reset_full got %b%b want 00", full0, afull0); end
        n_cmp++; if (count0 !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count0); end
        n_cmp++; if (dout0 !== 8'h00 || dout1 !== 8'h00) begin n_err++; $display("FAIL reset_dout got %h/%h want 00/00", dout0, dout1); end
        n_cmp++; if (ovf0 !== 1'b0 || unf0 !== 1'b0) begin n_err++; $display("FAIL reset_err got %b%b want 00", ovf0, unf0); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        // First write after reset must land at address 0, which FWFT shows at once.
        cyc(1'b1, 1'b0, 8'hA5);
        n_cmp++; if (dout1 !== 8'hA5) begin n_err++; $display("FAIL reset_first_addr got %h want a5", dout1); end
    endtask

    task automatic test_fill_drain();
        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 8'(i));
            n_cmp++; if (count0 !== 5'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count0, i + 1); end
            n_cmp++; if (afull0 !== (i + 1 >= 14)) begin n_err++; $display("FAIL fill_afull[%0d] got %b want %b", i, afull0, (i + 1 >= 14)); end
        end
        n_cmp++; if (full0 !== 1'b1) begin n_err++; $display("FAIL fill_full got %b want 1", full0); end
        cyc(1'b1, 1'b0, 8'hAA);
        n_cmp++; if (ovf0 !== 1'b1) begin n_err++; $display("FAIL overflow_set got %b want 1", ovf0); end
        n_cmp++; if (count0 !== 5'd16) begin n_err++; $display("FAIL overflow_count got %0d want 16", count0); end
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            n_cmp++; if (dout0 !== 8'(i)) begin n_err++; $display("FAIL drain_dout[%0d] got %h want %h", i, dout0, 8'(i)); end
            n_cmp++; if (aempty0 !== (15 - i <= 2)) begin n_err++; $display("FAIL drain_aempty[%0d] got %b want %b", i, aempty0, (15 - i <= 2)); end
        end
        n_cmp++; if (empty0 !== 1'b1 || count0 !== 5'd0) begin n_err++; $display("FAIL drain_empty got %b/%0d want 1/0", empty0, count0); end
    endtask

    task automatic test_underflow();
        cyc(1'b0, 1'b1, 8'h00);
        n_cmp++; if (unf0 !== 1'b1) begin n_err++; $display("FAIL underflow_set got %b want 1", unf0); end
        n_cmp++; if (dout0 !== 8'h0F) begin n_err++; $display("FAIL underflow_dout got %h want 0f", dout0); end
        cyc(1'b1, 1'b1, 8'h5C);
        n_cmp++; if (count0 !== 5'd1) begin n_err++; $display("FAIL empty_rdwr_count got %0d want 1", count0); end
        n_cmp++; if (dout0 !== 8'h0F) begin n_err++; $display("FAIL empty_rdwr_dout got %h want 0f", dout0); end
        cyc(1'b0, 1'b1, 8'h00);
        n_cmp++; if (dout0 !== 8'h5C || empty0 !== 1'b1) begin n_err++; $display("FAIL empty_rdwr_read got %h/%b want 5c/1", dout0, empty0); end
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i));
        for (int k = 0; k < 20; k++) begin
            cyc(1'b1, 1'b1, 8'(16 + k));
            n_cmp++; if (dout0 !== 8'(k)) begin n_err++; $display("FAIL b2b_dout[%0d] got %h want %h", k, dout0, 8'(k)); end
            n_cmp++; if (count0 !== 5'd16 || ovf0 !== 1'b0) begin n_err++; $display("FAIL b2b_state[%0d] got %0d/%b want 16/0", k, count0, ovf0); end
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            n_cmp++; if (dout0 !== 8'(20 + i)) begin n_err++; $display("FAIL wrap_dout[%0d] got %h want %h", i, dout0, 8'(20 + i)); end
        end
        n_cmp++; if (empty0 !== 1'b1) begin n_err++; $display("FAIL wrap_empty got %b want 1", empty0); end
    endtask

    task automatic test_fwft();
        pulse_reset();
        cyc(1'b1, 1'b0, 8'h11);
        n_cmp++; if (dout1 !== 8'h11 || empty1 !== 1'b0) begin n_err++; $display("FAIL fwft_first got %h/%b want 11/0", dout1, empty1); end
        cyc(1'b1, 1'b0, 8'h22);
        n_cmp++; if (dout1 !== 8'h11) begin n_err++; $display("FAIL fwft_hold got %h want 11", dout1); end
        cyc(1'b0, 1'b1, 8'h00);
        n_cmp++; if (dout1 !== 8'h22) begin n_err++; $display("FAIL fwft_pop got %h want 22", dout1); end
        cyc(1'b0, 1'b1, 8'h00);
        n_cmp++; if (empty1 !== 1'b1 || dout1 !== 8'h00) begin n_err++; $display("FAIL fwft_empty got %b/%h want 1/00", empty1, dout1); end
    endtask

    task automatic test_clr();
        pulse_reset();
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h30 + i));
        cyc(1'b1, 1'b0, 8'hEE);
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1, 8'h00);
        n_cmp++; if (count0 !== 5'd7 || ovf0 !== 1'b1) begin n_err++; $display("FAIL clr_setup got %0d/%b want 7/1", count0, ovf0); end
        clr = 1'b1;
        cyc(1'b1, 1'b0, 8'h99);
        n_cmp++; if (count0 !== 5'd0 || empty0 !== 1'b1) begin n_err++; $display("FAIL clr_count got %0d/%b want 0/1", count0, empty0); end
        n_cmp++; if (ovf0 !== 1'b0 || dout0 !== 8'h00) begin n_err++; $display("FAIL clr_state got %b/%h want 0/00", ovf0, dout0); end
        cyc(1'b1, 1'b0, 8'h77);
        n_cmp++; if (dout1 !== 8'h77 || count0 !== 5'd1) begin n_err++; $display("FAIL clr_newwrite got %h/%0d want 77/1", dout1, count0); end
        cyc(1'b0, 1'b1, 8'h00);
        n_cmp++; if (dout0 !== 8'h77 || empty0 !== 1'b1) begin n_err++; $display("FAIL clr_newread got %h/%b want 77/1", dout0, empty0); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_underflow();
        test_back_to_back();
        test_fwft();
        test_clr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
